// File: rtl/spi_reg_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_reg_bank_pkg
// Description : Shared types and constants for the SPI command decoder and
//               register bank.
// Revision    : 1.0  initial release
// ============================================================================
package spi_reg_bank_pkg;

    typedef enum logic [1:0] {
        ST_CMD = 2'd0,
        ST_RD  = 2'd1,
        ST_WR  = 2'd2
    } state_t;

    // Command bits are counted down from the word MSB: index = WORD_SIZE - n.
    localparam int RW_BIT   = 1;
    localparam int INC_BIT  = 2;
    localparam int ADDR_LSB = 0;

    localparam logic [15:0] DEFAULT_ID_CODE = 16'h7C04;

    // Thermocouple register map
    localparam int ADDR_TC_ADC   = 0;
    localparam int ADDR_TC_CJ    = 1;
    localparam int ADDR_TC_FLAGS = 2;
    localparam int ADDR_TC_CFG   = 4;

endpackage
`default_nettype wire

// File: rtl/spi_reg_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_reg_bank_if
// Description : Word-level handshake between the SPI slave and the register
//               bank.
// Revision    : 1.0  initial release
// ============================================================================
interface spi_reg_bank_if #(
    parameter int WORD_SIZE = 16
);
    logic                 i_sce;
    logic [WORD_SIZE-1:0] i_wout;
    logic                 i_wstb;
    logic [WORD_SIZE-1:0] o_win;

    modport slave (
        input  i_sce,
        input  i_wout,
        input  i_wstb,
        output o_win
    );

    modport master (
        output i_sce,
        output i_wout,
        output i_wstb,
        input  o_win
    );
endinterface
`default_nettype wire

// File: rtl/spi_cmd_fsm.sv
`default_nettype none
// ============================================================================
// Module      : spi_cmd_fsm
// Description : Command/data word sequencer: state, address counter, INC
//               latch, read-snapshot and write enables.
// Revision    : 1.0  initial release
// ============================================================================
module spi_cmd_fsm
    import spi_reg_bank_pkg::*;
#(
    parameter int ADDR_BITS = 3,
    parameter int NUM_RO    = 4
) (
    input  wire logic                 i_clk,
    input  wire logic                 i_rst_n,
    input  wire logic                 i_sce,
    input  wire logic                 i_wstb,
    input  wire logic                 i_cmd_rw,
    input  wire logic                 i_cmd_inc,
    input  wire logic [ADDR_BITS-1:0] i_cmd_addr,
    output logic                      o_rd_mode,
    output logic                      o_rd_load,
    output logic [ADDR_BITS-1:0]      o_rd_addr,
    output logic                      o_wr_en,
    output logic                      o_err_set,
    output logic [ADDR_BITS-1:0]      o_wr_addr
);
    localparam logic [ADDR_BITS-1:0] c_num_ro = ADDR_BITS'(NUM_RO);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [ADDR_BITS-1:0]   r_addr;
    logic [ADDR_BITS-1:0]   w_addr_nxt;
    logic [ADDR_BITS-1:0]   w_addr_inc;
    logic                   r_inc;
    logic                   w_inc_nxt;
    logic                   w_ro_hit;

    assign w_addr_inc = r_addr + ADDR_BITS'(1);
    assign w_ro_hit   = (r_addr < c_num_ro);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_CMD;
            r_addr  <= '0;
            r_inc   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_inc   <= w_inc_nxt;
        end
    end

    // Frame end beats any word strobe in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_inc_nxt   = r_inc;
        o_rd_load   = 1'b0;
        o_rd_addr   = r_addr;
        o_wr_en     = 1'b0;
        o_err_set   = 1'b0;
        if (i_sce) begin
            w_state_nxt = ST_CMD;
        end else if (i_wstb) begin
            case (r_state)
                ST_CMD: begin
                    w_addr_nxt = i_cmd_addr;
                    w_inc_nxt  = i_cmd_inc;
                    if (i_cmd_rw) begin
                        w_state_nxt = ST_WR;
                    end else begin
                        w_state_nxt = ST_RD;
                        o_rd_load   = 1'b1;
                        o_rd_addr   = i_cmd_addr;
                    end
                end
                ST_RD: begin
                    if (r_inc) begin
                        w_addr_nxt = w_addr_inc;
                        o_rd_load  = 1'b1;
                        o_rd_addr  = w_addr_inc;
                    end else begin
                        w_state_nxt = ST_CMD;
                    end
                end
                ST_WR: begin
                    o_wr_en   = ~w_ro_hit;
                    o_err_set = w_ro_hit;
                    if (r_inc) begin
                        w_addr_nxt = w_addr_inc;
                    end else begin
                        w_state_nxt = ST_CMD;
                    end
                end
                default: w_state_nxt = ST_CMD;
            endcase
        end
    end

    assign o_rd_mode = (r_state == ST_RD);
    assign o_wr_addr = r_addr;

endmodule
`default_nettype wire

// File: rtl/spi_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : spi_reg_bank
// Description : SPI word command decoder with read-only status and
//               read/write config registers, single and burst access.
// Revision    : 1.0  initial release
// ============================================================================
module spi_reg_bank
    import spi_reg_bank_pkg::*;
#(
    parameter int                   WORD_SIZE = 16,
    parameter int                   ADDR_BITS = 3,
    parameter int                   NUM_RO    = 4,
    parameter logic [WORD_SIZE-1:0] ID_CODE   = WORD_SIZE'(DEFAULT_ID_CODE)
) (
    input  wire logic                                        i_clk,
    input  wire logic                                        i_rst_n,
    spi_reg_bank_if.slave                                    bus,
    input  wire logic [NUM_RO*WORD_SIZE-1:0]                 i_status,
    output logic [((2**ADDR_BITS)-NUM_RO)*WORD_SIZE-1:0]     o_cfg,
    output logic                                             o_cfg_wstb,
    output logic [ADDR_BITS-1:0]                             o_cfg_waddr,
    output logic                                             o_err
);
    localparam int NUM_REGS = 2**ADDR_BITS;
    localparam int NUM_CFG  = NUM_REGS - NUM_RO;

    logic [WORD_SIZE-1:0] r_cfg [NUM_CFG];
    logic [WORD_SIZE-1:0] w_regs [NUM_REGS];
    logic [WORD_SIZE-1:0] r_snap;
    logic                 r_err;
    logic                 r_cfg_wstb;
    logic [ADDR_BITS-1:0] r_cfg_waddr;

    logic                 w_rd_mode;
    logic                 w_rd_load;
    logic [ADDR_BITS-1:0] w_rd_addr;
    logic                 w_wr_en;
    logic                 w_err_set;
    logic [ADDR_BITS-1:0] w_wr_addr;

    spi_cmd_fsm #(
        .ADDR_BITS (ADDR_BITS),
        .NUM_RO    (NUM_RO)
    ) u_fsm (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_sce      (bus.i_sce),
        .i_wstb     (bus.i_wstb),
        .i_cmd_rw   (bus.i_wout[WORD_SIZE-RW_BIT]),
        .i_cmd_inc  (bus.i_wout[WORD_SIZE-INC_BIT]),
        .i_cmd_addr (bus.i_wout[ADDR_LSB +: ADDR_BITS]),
        .o_rd_mode  (w_rd_mode),
        .o_rd_load  (w_rd_load),
        .o_rd_addr  (w_rd_addr),
        .o_wr_en    (w_wr_en),
        .o_err_set  (w_err_set),
        .o_wr_addr  (w_wr_addr)
    );

    // Flat address map feeding the read mux.
    for (genvar k = 0; k < NUM_RO; k++) begin : g_ro
        assign w_regs[k] = i_status[k*WORD_SIZE +: WORD_SIZE];
    end

    for (genvar j = 0; j < NUM_CFG; j++) begin : g_cfg
        assign w_regs[NUM_RO+j]           = r_cfg[j];
        assign o_cfg[j*WORD_SIZE +: WORD_SIZE] = r_cfg[j];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int j = 0; j < NUM_CFG; j++) begin
                r_cfg[j] <= '0;
            end
            r_snap      <= '0;
            r_err       <= 1'b0;
            r_cfg_wstb  <= 1'b0;
            r_cfg_waddr <= '0;
        end else begin
            for (int j = 0; j < NUM_CFG; j++) begin
                if (w_wr_en && (w_wr_addr == ADDR_BITS'(NUM_RO + j))) begin
                    r_cfg[j] <= bus.i_wout;
                end
            end
            if (w_rd_load) begin
                r_snap <= w_regs[w_rd_addr];
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
            r_cfg_wstb <= w_wr_en;
            if (w_wr_en) begin
                r_cfg_waddr <= w_wr_addr;
            end
        end
    end

    // Outside a read the ID word is shifted out; bit0 carries the error flag.
    assign bus.o_win   = w_rd_mode ? r_snap : {ID_CODE[WORD_SIZE-1:1], r_err};
    assign o_cfg_wstb  = r_cfg_wstb;
    assign o_cfg_waddr = r_cfg_waddr;
    assign o_err       = r_err;

endmodule
`default_nettype wire
